// File: rtl/score_argmax.sv
// Argmax over a frame of signed Q8.8 class scores; result is held on a valid/ready handshake.
// Define SCORE_ARGMAX_RUNNERUP_EN to add the runner-up score and margin outputs.
module score_argmax #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned IDX_W       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_class,
   output logic [DATA_W-1:0] out_score,
   output logic              out_err,
`ifdef SCORE_ARGMAX_RUNNERUP_EN
   output logic [DATA_W-1:0] out_second,
   output logic [DATA_W:0]   out_margin,
`endif
   output logic [7:0]        frame_cnt
);

   localparam logic [DATA_W-1:0] MinScore = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(NUM_CLASSES - 1);

   typedef enum logic [0:0] {StAccum, StHold} state_e;

   state_e              r_state;
   state_e              w_state_nxt;
   logic [IDX_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_best;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    r_out_class;
   logic [DATA_W-1:0]   r_out_score;
   logic                r_out_err;
   logic [7:0]          r_frame_cnt;

   logic                w_accept;
   logic                w_first;
   logic                w_at_last;
   logic                w_gt_best;
   logic                w_close;
   logic                w_err;
   logic                w_out_hs;
   logic [DATA_W-1:0]   w_best_nxt;
   logic [IDX_W-1:0]    w_idx_nxt;

`ifdef SCORE_ARGMAX_RUNNERUP_EN
   logic [DATA_W-1:0]   r_second;
   logic [DATA_W-1:0]   r_out_second;
   logic [DATA_W:0]     r_out_margin;
   logic [DATA_W-1:0]   w_second_nxt;
   logic [DATA_W:0]     w_margin;
`endif

   // Running best including the current beat; beat 0 always seeds the register.
   always_comb begin
      w_accept   = in_valid & (r_state == StAccum);
      w_first    = (r_cnt == '0);
      w_at_last  = (r_cnt == LastIdx);
      w_gt_best  = $signed(in_data) > $signed(r_best);
      w_close    = w_accept & (in_last | w_at_last);
      w_err      = in_last != w_at_last;
      w_out_hs   = (r_state == StHold) & out_ready;
      w_best_nxt = r_best;
      w_idx_nxt  = r_idx;
      if (w_first || w_gt_best) begin
         w_best_nxt = in_data;
         w_idx_nxt  = r_cnt;
      end
   end

`ifdef SCORE_ARGMAX_RUNNERUP_EN
   always_comb begin
      w_second_nxt = r_second;
      if (w_first) begin
         w_second_nxt = MinScore;
      end else if (w_gt_best) begin
         w_second_nxt = r_best;
      end else if ($signed(in_data) > $signed(r_second)) begin
         w_second_nxt = in_data;
      end
      // Sign-extend one bit so the difference of two signed scores never wraps.
      w_margin = {w_best_nxt[DATA_W-1], w_best_nxt} - {w_second_nxt[DATA_W-1], w_second_nxt};
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      unique case (r_state)
         StAccum: begin
            in_ready = 1'b1;
            if (w_close) begin
               w_state_nxt = StHold;
            end
         end
         StHold: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = StAccum;
            end
         end
         default: w_state_nxt = StAccum;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StAccum;
         r_cnt       <= '0;
         r_best      <= MinScore;
         r_idx       <= '0;
         r_out_class <= '0;
         r_out_score <= '0;
         r_out_err   <= 1'b0;
         r_frame_cnt <= 8'd0;
`ifdef SCORE_ARGMAX_RUNNERUP_EN
         r_second     <= MinScore;
         r_out_second <= MinScore;
         r_out_margin <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_best <= w_best_nxt;
            r_idx  <= w_idx_nxt;
            r_cnt  <= r_cnt + IDX_W'(1);
`ifdef SCORE_ARGMAX_RUNNERUP_EN
            r_second <= w_second_nxt;
`endif
         end
         if (w_close) begin
            r_out_class <= w_idx_nxt;
            r_out_score <= w_best_nxt;
            r_out_err   <= w_err;
`ifdef SCORE_ARGMAX_RUNNERUP_EN
            r_out_second <= w_second_nxt;
            r_out_margin <= w_margin;
`endif
         end
         if (w_out_hs) begin
            r_cnt       <= '0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign out_class = r_out_class;
   assign out_score = r_out_score;
   assign out_err   = r_out_err;
   assign frame_cnt = r_frame_cnt;
`ifdef SCORE_ARGMAX_RUNNERUP_EN
   assign out_second = r_out_second;
   assign out_margin = r_out_margin;
`endif

endmodule
